// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the flexible FIFO.
package fifo_pkg;

   localparam int FIFO_MODE_STD  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   function automatic bit is_pow2(input int value);
      return (value >= 2) && ((value & (value - 1)) == 0);
   endfunction

endpackage

// File: rtl/fifo_flex_if.sv
// Producer/consumer bundle for fifo_flex: data, handshakes, status and error flags.
interface fifo_flex_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 5
);

   logic [DATA_WIDTH-1:0] din;
   logic                  wr_en;
   logic                  fifo_full;
   logic                  fifo_afull;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] dout;
   logic                  fifo_empty;
   logic                  fifo_aempty;
   logic [ADDR_WIDTH:0]   count;
   logic                  err_clr;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output din, wr_en, rd_en, err_clr,
      input  dout, fifo_full, fifo_afull, fifo_empty, fifo_aempty, count, overflow, underflow
   );

   modport slave (
      input  din, wr_en, rd_en, err_clr,
      output dout, fifo_full, fifo_afull, fifo_empty, fifo_aempty, count, overflow, underflow
   );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer; the MSB is the lap bit used for full/empty disambiguation.
module fifo_ptr #(
   parameter int PTR_WIDTH = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_inc,
   output logic [PTR_WIDTH-1:0] o_ptr
);

   logic [PTR_WIDTH-1:0] r_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (i_inc) begin
         r_ptr <= r_ptr + PTR_WIDTH'(1);
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_flex.sv
// Single-clock FIFO with registered or fall-through read, threshold flags,
// occupancy count and sticky overflow/underflow flags.
module fifo_flex
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 32,
   parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
   parameter int FWFT       = 0,
   parameter int AFULL_TH   = FIFO_DEPTH - 2,
   parameter int AEMPTY_TH  = 2
) (
   input  logic        clk,
   input  logic        rst,
   fifo_flex_if.slave  bus
);

   if (!is_pow2(FIFO_DEPTH)) begin : g_bad_depth
      $error("fifo_flex: FIFO_DEPTH must be a power of 2 and >= 2");
   end
   if (ADDR_WIDTH != $clog2(FIFO_DEPTH)) begin : g_bad_aw
      $error("fifo_flex: ADDR_WIDTH must equal clog2(FIFO_DEPTH)");
   end
   if (AFULL_TH < 1 || AFULL_TH > FIFO_DEPTH) begin : g_bad_afull
      $error("fifo_flex: AFULL_TH out of range");
   end
   if (AEMPTY_TH < 0 || AEMPTY_TH > FIFO_DEPTH - 1) begin : g_bad_aempty
      $error("fifo_flex: AEMPTY_TH out of range");
   end

   localparam int                PW        = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH:0] LP_AFULL  = AFULL_TH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] LP_AEMPTY = AEMPTY_TH[ADDR_WIDTH:0];

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [ADDR_WIDTH:0]   w_rd_ptr;
   logic [ADDR_WIDTH:0]   w_wr_ptr;
   logic [ADDR_WIDTH:0]   w_count;
   logic [ADDR_WIDTH-1:0] w_rd_addr;
   logic [ADDR_WIDTH-1:0] w_wr_addr;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_rd_acc;
   logic                  w_wr_acc;
   logic                  r_overflow;
   logic                  r_underflow;

   assign w_rd_addr = w_rd_ptr[ADDR_WIDTH-1:0];
   assign w_wr_addr = w_wr_ptr[ADDR_WIDTH-1:0];
   assign w_count   = w_wr_ptr - w_rd_ptr;
   assign w_empty   = (w_rd_addr == w_wr_addr) && (w_rd_ptr[ADDR_WIDTH] == w_wr_ptr[ADDR_WIDTH]);
   assign w_full    = (w_rd_addr == w_wr_addr) && (w_rd_ptr[ADDR_WIDTH] != w_wr_ptr[ADDR_WIDTH]);

   // A pop in the same cycle frees a slot, so a write into a full FIFO is
   // accepted alongside it; a write never satisfies a read of an empty FIFO.
   assign w_rd_acc  = bus.rd_en && !w_empty;
   assign w_wr_acc  = bus.wr_en && (!w_full || w_rd_acc);

   fifo_ptr #(.PTR_WIDTH(PW)) u_rd_ptr (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_rd_acc),
      .o_ptr (w_rd_ptr)
   );

   fifo_ptr #(.PTR_WIDTH(PW)) u_wr_ptr (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_wr_acc),
      .o_ptr (w_wr_ptr)
   );

   always_ff @(posedge clk) begin
      if (w_wr_acc && !rst) begin
         r_mem[w_wr_addr] <= bus.din;
      end
   end

   if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign bus.dout = w_empty ? '0 : r_mem[w_rd_addr];
   end else begin : g_std
      logic [DATA_WIDTH-1:0] r_dout;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_dout <= '0;
         end else if (w_rd_acc) begin
            r_dout <= r_mem[w_rd_addr];
         end
      end

      assign bus.dout = r_dout;
   end

   // Set wins over clear so an error in the clearing cycle is not lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (bus.wr_en && !w_wr_acc) begin
            r_overflow <= 1'b1;
         end else if (bus.err_clr) begin
            r_overflow <= 1'b0;
         end
         if (bus.rd_en && !w_rd_acc) begin
            r_underflow <= 1'b1;
         end else if (bus.err_clr) begin
            r_underflow <= 1'b0;
         end
      end
   end

   assign bus.count       = w_count;
   assign bus.fifo_full   = w_full;
   assign bus.fifo_empty  = w_empty;
   assign bus.fifo_afull  = (w_count >= LP_AFULL);
   assign bus.fifo_aempty = (w_count <= LP_AEMPTY);
   assign bus.overflow    = r_overflow;
   assign bus.underflow   = r_underflow;

endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
Parametrised single-clock FIFO. Successor to the basic synchronous FIFO, adding:
- selectable first-word-fall-through (FWFT) read mode
- programmable almost-full and almost-empty thresholds
- occupancy count
- sticky overflow/underflow error flags with clear

Used as the generic buffer between pipeline stages and peripherals (e.g. UART/MMIO queues) in the core.

Parameters:
- DATA_WIDTH, 16, word width in bits.
- FIFO_DEPTH, 32, number of entries; must be a power of 2 and >= 2.
- ADDR_WIDTH, $clog2(FIFO_DEPTH), entry address width; derived, do not override.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
- AFULL_TH, FIFO_DEPTH-2, fifo_afull asserts when count >= AFULL_TH; range 1..FIFO_DEPTH.
- AEMPTY_TH, 2, fifo_aempty asserts when count <= AEMPTY_TH; range 0..FIFO_DEPTH-1.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- din  input  DATA_WIDTH  write data.
- wr_en  input  1  write request.
- fifo_full  output  1  count == FIFO_DEPTH.
- fifo_afull  output  1  count >= AFULL_TH.
- rd_en  input  1  read request (pop/acknowledge in FWFT mode).
- dout  output  DATA_WIDTH  read data.
- fifo_empty  output  1  count == 0.
- fifo_aempty  output  1  count <= AEMPTY_TH.
- count  output  ADDR_WIDTH+1  current occupancy, 0..FIFO_DEPTH.
- err_clr  input  1  clears the sticky error flags.
- overflow  output  1  sticky: a write was attempted while full and not accepted.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high. It overrides all other inputs in the same cycle, including mid-operation.
- Pointers: rd_ptr and wr_ptr are ADDR_WIDTH+1 bits; the MSB is the wrap bit. Both reset to 0.
- Address: entry address = ptr[ADDR_WIDTH-1:0]. Wrap-around is natural modulo 2^(ADDR_WIDTH+1).
- count = wr_ptr - rd_ptr, taken modulo 2^(ADDR_WIDTH+1).
- Full/empty decode: full when addresses are equal and wrap bits differ; empty when addresses are equal and wrap bits are equal.
- Status flags: full, empty, afull, aempty and count are combinational from the registered pointers only. There is no combinational path from wr_en/rd_en to any flag.
- After reset: count=0, empty=1, aempty=1, full=0, afull=0, overflow=0, underflow=0, dout=0.
- Write accept: wr_acc = wr_en & (!full | rd_acc). A simultaneous pop frees a slot, so write-while-full is accepted when a read is also accepted.
- On wr_acc: mem[wr_addr] <= din; wr_ptr+1.
- Read accept: rd_acc = rd_en & !empty. There is no write-to-read bypass: read-while-empty is always rejected, even with a simultaneous write.
- FWFT=0 (registered read): on rd_acc, dout <= mem[rd_addr] and rd_ptr+1. Data appears one cycle after the pop. dout holds its last value otherwise.
- FWFT=1 (fall-through): dout = mem[rd_addr] combinationally and is valid whenever fifo_empty=0. rd_en pops the displayed word; the next word is shown the following cycle. dout is don't-care while empty. A written word is visible on dout one cycle after the write into an empty FIFO.
- Simultaneous rd_acc & wr_acc: count unchanged and flags unchanged.
- Errors: overflow <= 1 when wr_en & !wr_acc. underflow <= 1 when rd_en & !rd_acc. Rejected requests change no pointer, no memory and no dout.
- Error clear: err_clr clears both flags. Set has priority over clear in the same cycle.
- Memory has no reset; only pointers, dout and the error flags reset.
- Elaboration checks: fail if FIFO_DEPTH is not a power of 2, or if either threshold is out of range.

Decomposition:
- Shared package fifo_pkg: the read-mode constants FIFO_MODE_STD=0 and FIFO_MODE_FWFT=1, plus a function checking that FIFO_DEPTH is a power of 2.
- One natural sub-module, fifo_ptr: an ADDR_WIDTH+1 wrapping pointer with an increment enable and synchronous reset. It is instantiated twice, once for read and once for write.
- Flags, count and error logic stay in fifo_flex.

Test Plan:
1. DEPTH=4, FWFT=0. Reset, then write 0xA1..0xA4 on consecutive cycles -> count 1,2,3,4; afull (TH=2) asserts at count 2; full=1 after the 4th write. A 5th write of 0xA5 -> overflow=1, count stays 4. Four reads -> dout 0xA1..0xA4, each one cycle after its rd_en; empty=1 at the end.
2. DEPTH=4, full. wr_en & rd_en for one cycle with din=0xB0 -> count stays 4, no overflow. Draining yields 0xA2, 0xA3, 0xA4, 0xB0.
3. DEPTH=4, FWFT=1. Write 0x55 into an empty FIFO -> next cycle empty=0 and dout=0x55 with no rd_en. Pop -> empty=1. A further rd_en -> underflow=1 and dout is not popped.
4. Empty FIFO with wr_en & rd_en in the same cycle (din=0x33) -> write accepted, underflow=1, count=1. err_clr -> underflow=0. err_clr asserted together with a new bad read -> underflow stays 1.
5. Wrap-around: 10 push/pop pairs through DEPTH=4 with data 0..9 -> data returns in order, count never exceeds 1, and the full/empty decode stays correct across the pointer MSB toggle.
6. Reset mid-operation: with count=3 and overflow=1, assert rst for one cycle alongside wr_en -> count=0, empty=1, overflow=0, dout=0, and the write is ignored.
